// File: rtl/orbtrace_pkg.sv
// Shared constants and types for the orbtrace transmit path.
// Holds the default FIFO depth and the occupancy-counter width helper.
package orbtrace_pkg;

    // Default storage depth exponent: 2**6 = 64 bytes
    localparam int TXFIFO_DEPTH_LOG2 = 6;

    // Occupancy counters need one extra bit so that "completely full" is representable
    localparam int TXFIFO_LEVEL_W = TXFIFO_DEPTH_LOG2 + 1;

    typedef logic [7:0] byte_t;

    // Width of a level/pointer field for a given depth exponent
    function automatic int level_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port byte store: one write port, one registered read port.
// The read register is reset so the byte presented downstream starts at 0x00.
module fifo_ram
    import orbtrace_pkg::*;
#(
    parameter int ADDR_W = TXFIFO_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  byte_t             wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output byte_t             rd_data
);

    byte_t mem [2**ADDR_W];
    byte_t rd_data_reg;

    // Storage write; contents are never cleared, only the pointers gate visibility
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read, loaded only when a byte is actually popped so it holds between pops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/tx_byte_fifo.sv
// Byte FIFO between the packet splitter and the UART transmitter.
// Pops are paced by txFree/ctsIn and never issued on consecutive cycles.
// Optional high-water-mark statistics: define TXFIFO_STATS_EN to add hwm/clrStats.
module tx_byte_fifo
    import orbtrace_pkg::*;
#(
    parameter int DEPTH_LOG2 = TXFIFO_DEPTH_LOG2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 inAvail,
    input  logic [7:0]                           inData,
    output logic                                 inNext,
    input  logic                                 txFree,
    input  logic                                 ctsIn,
    output logic                                 txStrobe,
    output logic [7:0]                           txByte,
    input  logic                                 flush,
    output logic [level_width(DEPTH_LOG2)-1:0]   level,
    output logic                                 full,
    output logic                                 empty
`ifdef TXFIFO_STATS_EN
    ,
    input  logic                                 clrStats,
    output logic [level_width(DEPTH_LOG2)-1:0]   hwm
`endif
);

    localparam int                 LEVEL_W = level_width(DEPTH_LOG2);
    localparam logic [LEVEL_W-1:0] ONE     = LEVEL_W'(1);

    logic [LEVEL_W-1:0] wr_ptr_reg;
    logic [LEVEL_W-1:0] rd_ptr_reg;
    logic [LEVEL_W-1:0] level_reg;
    logic [LEVEL_W-1:0] level_next;
    logic               strobe_reg;
    logic               push;
    logic               pop;

    // Full/empty come straight from the pointer registers: same index, MSB decides which
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                   (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);

    // A full FIFO refuses a push even if a pop happens in the same cycle
    assign push   = inAvail & ~full & ~flush;
    assign pop    = ~empty & txFree & ctsIn & ~strobe_reg & ~flush;
    assign inNext = push;

    // Occupancy update: flush wins, simultaneous push/pop cancel out
    always_comb begin
        level_next = level_reg;
        if (flush) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level_reg + ONE;
        end else if (pop && !push) begin
            level_next = level_reg - ONE;
        end
    end

    // Pointer, level and strobe registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            strobe_reg <= 1'b0;
        end else begin
            level_reg  <= level_next;
            strobe_reg <= pop;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + ONE;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + ONE;
                end
            end
        end
    end

    assign level    = level_reg;
    assign txStrobe = strobe_reg;

    // The RAM read register is txByte itself: it loads the head byte on the popping edge
    fifo_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg[DEPTH_LOG2-1:0]),
        .wr_data (inData),
        .rd_en   (pop),
        .rd_addr (rd_ptr_reg[DEPTH_LOG2-1:0]),
        .rd_data (txByte)
    );

`ifdef TXFIFO_STATS_EN
    logic [LEVEL_W-1:0] hwm_reg;

    // High-water mark of occupancy; clrStats restarts it from the present level, flush leaves it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm_reg <= '0;
        end else if (clrStats) begin
            hwm_reg <= level_reg;
        end else if (level_reg > hwm_reg) begin
            hwm_reg <= level_reg;
        end
    end

    assign hwm = hwm_reg;
`endif

endmodule
